// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - registered ALU issue stage: opcode-to-control mapping, pseudo-op operand rewrite, handshaked output
//
// Accepts decoded ops plus register read data and presents one registered
// ALU operation per cycle to the execute stage. Opcodes 0x8-0xF are consumed
// without being issued and are recorded in a sticky flag and a counter.
//
// Build option: ALU_OP_ISSUE_SKID_EN
//   defined   - output register plus one skid entry; in_ready comes only from
//               flop state, so out_ready has no combinational path to in_ready.
//   undefined - output register only; in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous clear of all held operations
//   in_valid / in_ready     upstream handshake
//   in_opcode, in_dest      decoded fields (4-bit opcode, DEST_W index)
//   in_operand1/2           16-bit register read data
//   out_valid / out_ready   downstream handshake
//   control                 3-bit ALU control code
//   operand1/2, dest        ALU operands and destination index
//   err_illegal             sticky illegal-opcode flag (reset only)
//   issue_count             output transfers, wraps at 2^CNT_W
//   illegal_count           illegal opcodes dropped, wraps at 2^CNT_W

module alu_op_issue #(
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [15:0]       in_operand1,
  input  logic [15:0]       in_operand2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        control,
  output logic [15:0]       operand1,
  output logic [15:0]       operand2,
  output logic [DEST_W-1:0] dest,
  output logic              err_illegal,
  output logic [CNT_W-1:0]  issue_count,
  output logic [CNT_W-1:0]  illegal_count
);

  logic        dec_legal;
  logic [2:0]  dec_control;
  logic [15:0] dec_op1;
  logic [15:0] dec_op2;

  always_comb begin
    dec_legal   = 1'b1;
    dec_control = 3'b000;
    dec_op1     = in_operand1;
    dec_op2     = in_operand2;
    case (in_opcode)
      4'h0: dec_control = 3'b000;
      4'h1: dec_control = 3'b001;
      4'h2: dec_control = 3'b010;
      4'h3: dec_control = 3'b011;
      4'h4: dec_control = 3'b100;
      4'h5: dec_control = 3'b101;
      // MOV: OR with zero passes operand1 through
      4'h6: begin
        dec_control = 3'b100;
        dec_op2     = 16'h0000;
      end
      // CLR: XOR of a value with itself yields zero
      4'h7: begin
        dec_control = 3'b101;
        dec_op2     = in_operand1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic in_xfer;
  logic out_xfer;
  logic out_free;
  logic load_legal;
  logic drop_illegal;

  assign in_xfer      = in_valid & in_ready;
  assign out_xfer     = out_valid & out_ready;
  assign out_free     = !out_valid | out_ready;
  // Anything accepted during a flush cycle is discarded without side effects
  assign load_legal   = in_xfer & dec_legal & !flush;
  assign drop_illegal = in_xfer & !dec_legal & !flush;

`ifdef ALU_OP_ISSUE_SKID_EN
  logic              skid_valid;
  logic [2:0]        skid_control;
  logic [15:0]       skid_op1;
  logic [15:0]       skid_op2;
  logic [DEST_W-1:0] skid_dest;

  // Skid entry empty means one more op can be absorbed even if the output stalls
  assign in_ready = !skid_valid;
`else
  assign in_ready = out_free;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      control      <= 3'b000;
      operand1     <= 16'h0000;
      operand2     <= 16'h0000;
      dest         <= '0;
`ifdef ALU_OP_ISSUE_SKID_EN
      skid_valid   <= 1'b0;
      skid_control <= 3'b000;
      skid_op1     <= 16'h0000;
      skid_op2     <= 16'h0000;
      skid_dest    <= '0;
`endif
    end else if (flush) begin
      out_valid  <= 1'b0;
      control    <= 3'b000;
      operand1   <= 16'h0000;
      operand2   <= 16'h0000;
      dest       <= '0;
`ifdef ALU_OP_ISSUE_SKID_EN
      skid_valid <= 1'b0;
`endif
    end else begin
`ifdef ALU_OP_ISSUE_SKID_EN
      if (out_free) begin
        // The skid entry is always older than the incoming op; in_ready is
        // low whenever it is occupied, so no new op competes with it here.
        if (skid_valid) begin
          out_valid  <= 1'b1;
          control    <= skid_control;
          operand1   <= skid_op1;
          operand2   <= skid_op2;
          dest       <= skid_dest;
          skid_valid <= 1'b0;
        end else if (load_legal) begin
          out_valid <= 1'b1;
          control   <= dec_control;
          operand1  <= dec_op1;
          operand2  <= dec_op2;
          dest      <= in_dest;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (load_legal) begin
        skid_valid   <= 1'b1;
        skid_control <= dec_control;
        skid_op1     <= dec_op1;
        skid_op2     <= dec_op2;
        skid_dest    <= in_dest;
      end
`else
      if (out_free) begin
        if (load_legal) begin
          out_valid <= 1'b1;
          control   <= dec_control;
          operand1  <= dec_op1;
          operand2  <= dec_op2;
          dest      <= in_dest;
        end else begin
          out_valid <= 1'b0;
        end
      end
`endif
    end
  end

  // Status is deliberately outside the flush domain: only reset clears it.
  // An output transfer in a flush cycle still happened, so it is counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_illegal   <= 1'b0;
      issue_count   <= '0;
      illegal_count <= '0;
    end else begin
      if (out_xfer) begin
        issue_count <= issue_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (drop_illegal) begin
        err_illegal   <= 1'b1;
        illegal_count <= illegal_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - randomized self-checking bench for alu_op_issue against a queue reference model

module tb_alu_op_issue;

`ifdef ALU_OP_ISSUE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_dest;
  logic [15:0] in_operand1;
  logic [15:0] in_operand2;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  control;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic [3:0]  dest;
  logic        err_illegal;
  logic [15:0] issue_count;
  logic [15:0] illegal_count;

  always #5 clk = ~clk;

  alu_op_issue #(.DEST_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_operand1(in_operand1), .in_operand2(in_operand2),
    .out_valid(out_valid), .out_ready(out_ready), .control(control),
    .operand1(operand1), .operand2(operand2), .dest(dest),
    .err_illegal(err_illegal), .issue_count(issue_count),
    .illegal_count(illegal_count)
  );

  typedef struct packed {
    logic [2:0]  ctl;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  d;
  } op_t;

  // Reference model: ops accepted but not yet issued, in acceptance order
  op_t         exp_q[$];
  logic [15:0] m_issue;
  logic [15:0] m_illegal;
  logic        m_err;
  logic        last_ixf;
  int          checks = 0;
  int          errors = 0;

  function automatic op_t ref_op(input logic [3:0] opc, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] d);
    op_t r;
    r.ctl = (opc == 4'h6) ? 3'd4 : (opc == 4'h7) ? 3'd5 : opc[2:0];
    r.a   = a;
    r.b   = (opc == 4'h6) ? 16'h0000 : (opc == 4'h7) ? a : b;
    r.d   = d;
    return r;
  endfunction

  task automatic cycle();
    logic ixf, oxf, fl;
    logic [3:0] opc;
    op_t nop;
    @(negedge clk);
    ixf = in_valid && in_ready;
    oxf = out_valid && out_ready;
    fl  = flush;
    opc = in_opcode;
    nop = ref_op(in_opcode, in_operand1, in_operand2, in_dest);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      if (oxf) m_issue++;
    end else begin
      if (oxf) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_issue++;
      end
      if (ixf) begin
        if (opc < 4'h8) exp_q.push_back(nop);
        else begin
          m_illegal++;
          m_err = 1'b1;
        end
      end
    end
    last_ixf = ixf;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 4'h0; in_dest = 4'h0; in_operand1 = 16'h0; in_operand2 = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    m_issue = 16'h0; m_illegal = 16'h0; m_err = 1'b0; last_ixf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (control !== 3'b000) begin errors++; $display("FAIL reset_control: got %b expected 000", control); end
    checks++; if ({operand1, operand2} !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h %h expected 0 0", operand1, operand2); end
    checks++; if (dest !== 4'h0) begin errors++; $display("FAIL reset_dest: got %h expected 0", dest); end
    checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_illegal); end
    checks++; if ({issue_count, illegal_count} !== 32'h0) begin errors++; $display("FAIL reset_counts: got %h %h expected 0 0", issue_count, illegal_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_logic_op();
    out_ready = 1'b1; in_valid = 1'b1; in_opcode = 4'h3; in_dest = 4'h5;
    in_operand1 = 16'hF0F0; in_operand2 = 16'h0FF0;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_valid: got %b expected 1", out_valid); end
    checks++; if (control !== 3'b011) begin errors++; $display("FAIL and_control: got %b expected 011", control); end
    checks++; if ({operand1, operand2, dest} !== {16'hF0F0, 16'h0FF0, 4'h5}) begin errors++; $display("FAIL and_fields: got %h %h %h expected f0f0 0ff0 5", operand1, operand2, dest); end
    cycle();
    checks++; if (issue_count !== 16'd1) begin errors++; $display("FAIL and_issue_count: got %0d expected 1", issue_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_pseudo_ops();
    out_ready = 1'b1; in_valid = 1'b1; in_opcode = 4'h6; in_dest = 4'h2;
    in_operand1 = 16'h1234; in_operand2 = 16'($urandom);
    cycle();
    checks++; if ({out_valid, control, operand1, operand2} !== {1'b1, 3'b100, 16'h1234, 16'h0000}) begin errors++; $display("FAIL mov: got %b %b %h %h expected 1 100 1234 0000", out_valid, control, operand1, operand2); end
    in_opcode = 4'h7; in_operand1 = 16'hABCD; in_operand2 = 16'($urandom);
    cycle();
    in_valid = 1'b0;
    checks++; if ({out_valid, control, operand1, operand2} !== {1'b1, 3'b101, 16'hABCD, 16'hABCD}) begin errors++; $display("FAIL clr: got %b %b %h %h expected 1 101 abcd abcd", out_valid, control, operand1, operand2); end
    cycle();
    checks++; if (issue_count !== 16'd3) begin errors++; $display("FAIL pseudo_issue_count: got %0d expected 3", issue_count); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_opcode = 4'hB;
    cycle();
    flush = 1'b0;
    checks++; if ({err_illegal, illegal_count} !== {1'b0, 16'd0}) begin errors++; $display("FAIL illegal_in_flush: got %b %0d expected 0 0", err_illegal, illegal_count); end
    in_opcode = 4'hA;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_not_issued: got %b expected 0", out_valid); end
    checks++; if ({err_illegal, illegal_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL illegal_flag: got %b %0d expected 1 1", err_illegal, illegal_count); end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++; if ({err_illegal, illegal_count} !== {1'b1, 16'd1}) begin errors++; $display("FAIL illegal_sticky: got %b %0d expected 1 1", err_illegal, illegal_count); end
  endtask

  task automatic test_stall();
    int k;
    logic [15:0] got[$];
    do_reset();
    k = 1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k <= 3); in_opcode = 4'h0; in_dest = 4'(k);
      in_operand1 = 16'(k); in_operand2 = 16'($urandom);
      cycle();
      if (last_ixf) k++;
      checks++; if ({out_valid, operand1} !== {1'b1, 16'd1}) begin errors++; $display("FAIL stall_hold: got %b %h expected 1 0001", out_valid, operand1); end
      checks++; if (in_ready !== ((k - 1) < DEPTH)) begin errors++; $display("FAIL stall_in_ready: got %b after %0d accepted", in_ready, k - 1); end
    end
    checks++; if (k - 1 !== DEPTH) begin errors++; $display("FAIL stall_accepted: got %0d expected %0d", k - 1, DEPTH); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      in_valid = (k <= 3); in_dest = 4'(k); in_operand1 = 16'(k);
      if (out_valid) got.push_back(operand1);
      cycle();
      if (last_ixf) k++;
    end
    in_valid = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 16'(i + 1)) begin errors++; $display("FAIL stall_order[%0d]: got %0d expected %0d", i, got[i], i + 1); end
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_opcode = 4'hC;
    cycle();
    out_ready = 1'b0; in_opcode = 4'h1;
    for (int c = 0; c < 3; c++) begin
      in_operand1 = 16'(c + 10); in_operand2 = 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clears: got %b expected 0", out_valid); end
    checks++; if (issue_count !== 16'd0) begin errors++; $display("FAIL flush_issue_count: got %0d expected 0", issue_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_opcode = 4'h2; in_dest = 4'h9; in_operand1 = 16'h5555; in_operand2 = 16'h7777;
    cycle();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if ({out_valid, control, operand1, operand2, dest} !== 40'h0) begin errors++; $display("FAIL async_reset_out: got %b %b %h %h %h expected all 0", out_valid, control, operand1, operand2, dest); end
    checks++; if ({err_illegal, issue_count, illegal_count} !== 33'h0) begin errors++; $display("FAIL async_reset_status: got %b %0d %0d expected 0 0 0", err_illegal, issue_count, illegal_count); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    op_t h;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_opcode = 4'($urandom_range(0, 7)); in_dest = 4'($urandom);
      in_operand1 = 16'($urandom); in_operand2 = 16'($urandom);
      cycle();
      h = (exp_q.size() > 0) ? exp_q[0] : '0;
      checks++; if ({out_valid, control, operand1, operand2, dest} !== {1'b1, h.ctl, h.a, h.b, h.d}) begin errors++; $display("FAIL b2b_out[%0d]: got %b %b %h %h %h expected 1 %b %h %h %h", c, out_valid, control, operand1, operand2, dest, h.ctl, h.a, h.b, h.d); end
    end
    in_valid = 1'b0;
    cycle();
    checks++; if (issue_count !== 16'd8) begin errors++; $display("FAIL b2b_issue_count: got %0d expected 8", issue_count); end
  endtask

  task automatic test_random();
    op_t h;
    logic exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom % 4) != 0;
      in_opcode   = (($urandom % 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      in_dest     = 4'($urandom);
      in_operand1 = 16'($urandom);
      in_operand2 = 16'($urandom);
      out_ready   = ($urandom % 3) != 0;
      flush       = ($urandom % 40) == 0;
      #1;
      exp_rdy = (DEPTH == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || out_ready);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy); end
      cycle();
      checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", c, out_valid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        checks++; if ({control, operand1, operand2, dest} !== {h.ctl, h.a, h.b, h.d}) begin errors++; $display("FAIL rand_fields[%0d]: got %b %h %h %h expected %b %h %h %h", c, control, operand1, operand2, dest, h.ctl, h.a, h.b, h.d); end
      end
      checks++; if ({issue_count, illegal_count, err_illegal} !== {m_issue, m_illegal, m_err}) begin errors++; $display("FAIL rand_status[%0d]: got %0d %0d %b expected %0d %0d %b", c, issue_count, illegal_count, err_illegal, m_issue, m_illegal, m_err); end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_logic_op();
    test_pseudo_ops();
    test_illegal();
    test_stall();
    test_flush_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Registered issue stage that sits upstream of the ALU's logic/arithmetic units and produces their 3-bit control code plus two 16-bit operands. It accepts decoded instruction fields and register-file read data over a valid/ready handshake, maps the 4-bit opcode to an ALU control code, rewrites operands for pseudo-ops, and presents one registered, handshaked operation per cycle to the execute stage. Illegal opcodes are dropped and flagged.

## Interface

- `DEST_W`, 4: destination register index width.
- `CNT_W`, 16: width of issue and illegal counters.

- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous flush; clears all held operations.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_opcode`  in  4  operation code.
- `in_dest`  in  DEST_W  destination register index.
- `in_operand1`, `in_operand2`  in  16  register read data.
- `out_valid`  out  1  operation valid to execute.
- `out_ready`  in  1  execute accepts this cycle.
- `control`  out  3  ALU control code.
- `operand1`, `operand2`  out  16  ALU operands.
- `dest`  out  DEST_W  destination index.
- `err_illegal`  out  1  sticky illegal-opcode flag.
- `issue_count`  out  CNT_W  operations issued (out_valid & out_ready).
- `illegal_count`  out  CNT_W  illegal opcodes dropped.

## Operation

- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- Opcode map (control, operand1, operand2):
  - 0x0 ADD → 3'b000, op1, op2; 0x1 SUB → 3'b001, op1, op2; 0x2 SLT → 3'b010, op1, op2.
  - 0x3 AND → 3'b011; 0x4 OR → 3'b100; 0x5 XOR → 3'b101 (operands unchanged).
  - 0x6 MOV → 3'b100 (OR), op1, 16'h0000.
  - 0x7 CLR → 3'b101 (XOR), op1, op1 (result zero).
  - 0x8–0xF illegal: accepted (consumed), never issued; set `err_illegal`, increment `illegal_count`.
- `err_illegal` is sticky; cleared only by reset (not by flush).
- Counters wrap modulo 2^CNT_W; not cleared by flush.
- Operations issue in acceptance order; none duplicated or lost except illegal ones and flushed ones.
- `flush`: next edge clears output register and skid entry (`out_valid`=0); any input transfer in the flush cycle is discarded and not counted (illegal in flush cycle does not set flag).
- Output fields hold stable while `out_valid & !out_ready`.

## Timing

- Latency: legal op accepted at edge N appears with `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: one op per cycle when `out_ready` held high.
- Reset (async assert, sync-safe release): `out_valid`=0, `control`=3'b000, `operand1`=`operand2`=0, `dest`=0, `err_illegal`=0, both counters 0, skid empty, `in_ready`=1 (skid build) / 1 (no-skid build, since `out_valid`=0).
- Reset mid-transfer: held ops discarded; no partial state survives.
- Simultaneous out transfer and in transfer of a legal op: output register reloads with the new op same edge, `out_valid` stays 1.
- Illegal op accepted while output stalled: consumed, output unchanged.

## Configuration

- `ALU_OP_ISSUE_SKID_EN` defined: two-entry buffer (output register + skid register). `in_ready` is a register output = skid empty; no combinational path from `out_ready` to `in_ready`. When output stalls, one further op is captured in skid; it moves to output on the next out transfer.
- Undefined: single output register; `in_ready = !out_valid | out_ready` (combinational). Behaviour otherwise identical, including latency and ordering.

## Test plan

- Reset then `in_opcode`=0x3, op1=16'hF0F0, op2=16'h0FF0, `out_ready`=1 → next cycle `out_valid`=1, `control`=3'b011, operands unchanged, `issue_count`=1 after transfer.
- Opcodes 0x6 (op1=16'h1234) and 0x7 (op1=16'hABCD) back-to-back → control 3'b100/op2=16'h0000, then 3'b101/op2=16'hABCD, consecutive cycles.
- Opcode 0xA with valid → no `out_valid`, `err_illegal`=1, `illegal_count`=1; flag persists through `flush`.
- `out_ready`=0 for 5 cycles while streaming ADD ops with op1=1,2,3 → outputs held stable; skid build: `in_ready` drops after 2 ops accepted; releasing `out_ready` issues 1,2,3 in order, none lost.
- Two ops buffered, assert `flush` one cycle → `out_valid`=0 next cycle, `issue_count` unchanged; assert `reset_n`=0 mid-stall → all outputs to reset values immediately.
